// File: rtl/lc3_pkg.sv
// Shared LC-3 fetch definitions: word width, opcode constants, fetch FSM
// states and the {pc, instr} record carried through the prefetch queue.
package lc3_pkg;
    localparam int WORD_W = 16;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/lc3_sync_fifo.sv
// Synchronous FIFO with flush and a registered head, so the head is stable
// from the cycle after a push and holds its last value once drained.
module lc3_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (i_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(i_push) - CW'(i_pop);
            // Incoming word becomes the head when it lands in the slot the read pointer moves to.
            if (count_d != '0)
                head_d = (i_push && wr_ptr_q == rd_ptr_d) ? i_wdata : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem_q[wr_ptr_q] <= i_wdata;
    end

    assign o_count = count_q;
    assign o_head  = head_q;
endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch: credit-limited in-order reads into a prefetch queue,
// stop after HALT, flush and restart on redirect with stale-response discard.
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h3000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [15:0] i_mem_rdata,
    output logic        o_instr_valid,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_halted
);
    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   CREDITS = (CW+1)'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [15:0]       fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d, discard_q, discard_d;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       in_use;
    logic              issue, push, pop, is_halt;
    fetch_entry_t      head, wentry;

    // Queue entries plus reads in flight never exceed the queue size, so responses always fit.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign o_mem_req = i_rst_n && (state_q == FETCH) && !i_redirect && (in_use < CREDITS);
    assign issue     = o_mem_req && i_mem_ready;
    assign push      = i_mem_rvalid && (discard_q == '0) && !i_redirect && (state_q == FETCH);
    assign pop       = o_instr_valid && i_instr_ready;
    assign is_halt   = i_mem_rdata[WORD_W-1 -: 4] == HALT_OPCODE;
    assign wentry    = '{pc: resp_pc_q, instr: i_mem_rdata};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(issue) - CW'(i_mem_rvalid);
        if (issue) fetch_pc_d = fetch_pc_q + 16'd1;
        if (push)  resp_pc_d  = resp_pc_q + 16'd1;
        if (i_mem_rvalid && discard_q != '0) discard_d = discard_q - CW'(1);
        if (push && is_halt) state_d = HALTED;
        // Everything still in flight after this cycle belongs to the abandoned stream.
        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            resp_pc_d  = i_redirect_pc;
            discard_d  = outstanding_d;
            state_d    = FETCH;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    lc3_sync_fifo #(
        .WIDTH (2 * WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_wdata (wentry),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .o_count (fifo_count),
        .o_head  (head)
    );

    assign o_mem_addr    = fetch_pc_q;
    assign o_instr_valid = fifo_count != '0;
    assign o_instr       = head.instr;
    assign o_instr_pc    = head.pc;
    assign o_halted      = state_q == HALTED;
endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Bench for lc3_fetch_unit: in-order latency memory model, sequential-stream
// reference model for issued and delivered PCs, scenario table plus corner sequences.
module tb_lc3_fetch_unit;
    logic        i_clk = 1'b0;
    logic        i_rst_n, o_mem_req, i_mem_ready, i_mem_rvalid;
    logic [15:0] o_mem_addr, i_mem_rdata, o_instr, o_instr_pc, i_redirect_pc;
    logic        o_instr_valid, i_instr_ready, i_redirect, o_halted;

    always #5 i_clk = ~i_clk;

    lc3_fetch_unit dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ready   (i_mem_ready),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_instr_ready (i_instr_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_halted      (o_halted)
    );

    typedef struct { logic [15:0] addr; int due; } rsp_t;
    typedef struct {
        logic [15:0] start_pc;
        int          lat, mem_pct, cons_pct, halt_at, pops;
        logic [15:0] exp_last_pc;
        logic        exp_halted;
    } scen_t;

    rsp_t        mq[$];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, last_due = 0, lat = 1, mem_pct = 100, cons_pct = 100;
    int          halt_addr = -1, n_pop = 0, n_issue = 0;
    logic [15:0] exp_pc, exp_issue, last_pop_pc;
    bit          stream_done;

    // Memory image: a ^ 16'h1000, with a single HALT word planted where requested.
    function automatic logic [15:0] memfun(input logic [15:0] a);
        if (int'(a) == halt_addr) return 16'hF025;
        return a ^ 16'h1000;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: cycle budget expired (cycle %0d)", name, cyc);
    endtask

    // One clock: drive at negedge, observe handshakes, then advance to the next negedge.
    task automatic tick(input bit redir, input logic [15:0] rpc);
        int d;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_mem_ready   = $urandom_range(0, 99) < mem_pct;
        i_instr_ready = $urandom_range(0, 99) < cons_pct;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = memfun(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = 16'($urandom);
        end
        #1;
        if (redir) chk("redir_noreq", o_mem_req, 1'b0);
        if (o_halted) chk("halt_noreq", o_mem_req, 1'b0);
        if (o_mem_req && i_mem_ready) begin
            chk("issue_addr", o_mem_addr, exp_issue);
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq.push_back('{addr: o_mem_addr, due: d});
            exp_issue++;
            n_issue++;
        end
        if (o_instr_valid && i_instr_ready) begin
            if (stream_done) timeout("pop_after_halt");
            chk("pop_pc", o_instr_pc, exp_pc);
            chk("pop_instr", o_instr, memfun(exp_pc));
            if (memfun(exp_pc) == 16'hF025) stream_done = 1'b1;
            last_pop_pc = o_instr_pc;
            exp_pc++;
            n_pop++;
        end
        if (redir) begin
            exp_pc      = rpc;
            exp_issue   = rpc;
            stream_done = 1'b0;
        end
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n       = 1'b0;
        i_redirect    = 1'b0;
        i_mem_rvalid  = 1'b0;
        i_mem_ready   = 1'b0;
        i_instr_ready = 1'b0;
        #1;
        chk("rst_req", o_mem_req, 1'b0);
        chk("rst_valid", o_instr_valid, 1'b0);
        chk("rst_instr", o_instr, 16'h0);
        chk("rst_pc", o_instr_pc, 16'h0);
        chk("rst_halted", o_halted, 1'b0);
        chk("rst_addr", o_mem_addr, 16'h3000);
        mq.delete();
        last_due    = 0;
        exp_pc      = 16'h3000;
        exp_issue   = 16'h3000;
        stream_done = 1'b0;
        halt_addr   = -1;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic run_pops(input int target, input string name);
        int budget = 400;
        while (n_pop < target && budget > 0) begin
            tick(1'b0, 16'h0);
            budget--;
        end
        if (n_pop < target) timeout(name);
    endtask

    scen_t tbl[5];

    initial begin
        int p0, ni, budget;
        bit seen;
        tbl[0] = '{16'h3000, 1, 100, 100, -1,      8,  16'h3007, 1'b0};
        tbl[1] = '{16'hFFFE, 1, 100, 100, -1,      4,  16'h0001, 1'b0};
        tbl[2] = '{16'h3000, 1, 100, 100, 'h3002,  3,  16'h3002, 1'b1};
        tbl[3] = '{16'h4000, 3, 60,  50,  -1,      12, 16'h400B, 1'b0};
        tbl[4] = '{16'h1234, 2, 30,  80,  'h1239,  6,  16'h1239, 1'b1};

        i_rst_n = 1'b1; i_redirect = 1'b0; i_redirect_pc = 16'h0;
        i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 16'h0; i_instr_ready = 1'b0;
        @(negedge i_clk);

        // Back-to-back fetch with 1-cycle memory: head valid two cycles after reset release.
        do_reset();
        lat = 1; mem_pct = 100; cons_pct = 100;
        tick(1'b0, 16'h0);
        chk("first_valid_c1", o_instr_valid, 1'b0);
        tick(1'b0, 16'h0);
        chk("first_valid_c2", o_instr_valid, 1'b1);
        chk("first_pc", o_instr_pc, 16'h3000);
        chk("first_instr", o_instr, 16'h2000);
        run_pops(n_pop + 6, "stream_pops");

        // Consumer stalled: credits stop fetching at exactly the queue depth.
        do_reset();
        cons_pct = 0; n_issue = 0;
        repeat (20) tick(1'b0, 16'h0);
        chk("bp_issues", 16'(n_issue), 16'd4);
        chk("bp_req", o_mem_req, 1'b0);
        chk("bp_valid", o_instr_valid, 1'b1);
        cons_pct = 100;
        run_pops(n_pop + 8, "bp_drain");

        // Redirect with three reads in flight under 3-cycle memory.
        do_reset();
        lat = 3;
        budget = 20;
        while (mq.size() != 3 && budget > 0) begin tick(1'b0, 16'h0); budget--; end
        if (mq.size() != 3) timeout("redir_setup");
        tick(1'b1, 16'h4000);
        chk("redir_flush", o_instr_valid, 1'b0);
        seen = 1'b0; budget = 30;
        while (!seen && budget > 0) begin
            if (o_instr_valid) begin
                seen = 1'b1;
                chk("redir_first_pc", o_instr_pc, 16'h4000);
            end else begin
                tick(1'b0, 16'h0);
                budget--;
            end
        end
        if (!seen) timeout("redir_refill");
        run_pops(n_pop + 4, "redir_pops");

        // Scenario table: start point, memory timing, consumer rate, optional HALT.
        foreach (tbl[i]) begin
            do_reset();
            lat = tbl[i].lat; mem_pct = tbl[i].mem_pct; cons_pct = tbl[i].cons_pct;
            halt_addr = tbl[i].halt_at;
            p0 = n_pop;
            if (tbl[i].start_pc != 16'h3000) tick(1'b1, tbl[i].start_pc);
            run_pops(p0 + tbl[i].pops, "tbl_pops");
            chk("tbl_last_pc", last_pop_pc, tbl[i].exp_last_pc);
            ni = n_issue;
            repeat (12) tick(1'b0, 16'h0);
            chk("tbl_halted", o_halted, tbl[i].exp_halted);
            if (tbl[i].exp_halted) begin
                chk("halt_quiet", 16'(n_issue - ni), 16'd0);
                chk("halt_valid", o_instr_valid, 1'b0);
                tick(1'b1, 16'h3000);
                chk("restart_halted", o_halted, 1'b0);
                run_pops(n_pop + 2, "restart_pops");
            end
        end

        // Asynchronous reset with a non-empty queue.
        do_reset();
        lat = 2; mem_pct = 100; cons_pct = 0;
        repeat (8) tick(1'b0, 16'h0);
        chk("pre_rst_valid", o_instr_valid, 1'b1);
        do_reset();
        i_mem_ready = 1'b1;
        #1;
        chk("rel_req", o_mem_req, 1'b1);
        chk("rel_addr", o_mem_addr, 16'h3000);
        cons_pct = 100;
        run_pops(n_pop + 4, "rel_pops");

        // Randomized traffic with sporadic redirects and HALT words.
        for (int r = 0; r < 30; r++) begin
            lat      = $urandom_range(1, 4);
            mem_pct  = $urandom_range(20, 100);
            cons_pct = $urandom_range(20, 100);
            p0 = $urandom_range(0, 16'hD000);
            halt_addr = ($urandom_range(0, 3) == 0) ? p0 + $urandom_range(0, 10) : -1;
            tick(1'b1, 16'(p0));
            for (int k = 0; k < 40; k++)
                tick($urandom_range(0, 19) == 0, 16'($urandom_range(0, 16'hD000)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
